conv_window_sched: RTL and testbench
====================================

Name: conv_window_sched

Overview:
- Controller that sequences the NPU image buffer, a ROWS x COLS, 8-bit RAM with one write port and two asynchronous read ports. The RAM writes at the port-1 address.
- LOAD phase: streams a full image into the buffer.
- SCAN phase: walks every KxK convolution window and issues two tap read addresses per cycle to the buffer, with valid and framing flags for the downstream MAC array.
- Sits between the pixel input stream and the buffer/MAC pair. Started by a single start pulse from the NPU top-level sequencer.

Parameters:
- ROWS, 28, image height
- COLS, 28, image width
- K, 3, kernel size (odd, >=1)
- AW, 10, buffer address width (2^AW >= ROWS*COLS)

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- start  in  1  begin LOAD; sampled only in IDLE
- busy  out  1  high in LOAD and SCAN
- done  out  1  one-cycle pulse at end of SCAN
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  high in LOAD
- pix_data  in  8  input pixel
- buf_wr_en  out  1  buffer write enable
- buf_wr_data  out  8  buffer write data
- buf_addr1  out  AW  buffer port-1 address (write address in LOAD, tap A in SCAN)
- buf_addr2  out  AW  buffer port-2 address (tap B)
- tap_valid  out  1  tap A valid this cycle
- tap2_valid  out  1  tap B valid this cycle
- tap_first  out  1  first pair of a window
- tap_last  out  1  last pair of a window
- out_row  out  $clog2(ROWS)  output row of current window
- out_col  out  $clog2(COLS)  output column of current window
- tap_zero1  out  1  tap A is padding (ZERO_PAD_EN only, else 0)
- tap_zero2  out  1  tap B is padding (ZERO_PAD_EN only, else 0)
- mac_ready  in  1  MAC accepts the current tap pair

Behaviour:
- Reset: state IDLE and every output 0.
  - Covers busy, done, pix_ready, buf_wr_en, buf_wr_data, both addresses, all tap flags, out_row, out_col.
  - Reset mid-LOAD or mid-SCAN aborts immediately with no done pulse.
- FSM states: IDLE -> LOAD -> SCAN -> DONE -> IDLE.
- IDLE:
  - start=1 -> LOAD and clear the load counter.
- LOAD:
  - pix_ready=1.
  - On each pix_valid && pix_ready, the next cycle drives buf_wr_en=1, buf_wr_data=pix_data, buf_addr1=counter, then increments the counter. Otherwise buf_wr_en=0.
  - After the ROWS*COLS-th accepted pixel (address ROWS*COLS-1), go to SCAN.
  - pix_ready drops in the same cycle as that handshake, so the pixel count is exact.
- SCAN, no padding:
  - Output grid: OR=ROWS-K+1 by OC=COLS-K+1, traversed row-major.
  - Taps t=0..K*K-1 are ordered row-major as (kr,kc).
  - Pair p covers taps 2p on port A and 2p+1 on port B; NPAIR=ceil(K*K/2).
  - addr = (out_row+kr)*COLS + (out_col+kc), computed at AW bits with no wrap.
  - When K*K is odd, the last pair has tap2_valid=0 and buf_addr2=0.
  - tap_first=1 when p=0; tap_last=1 when p=NPAIR-1.
  - All SCAN outputs are registered.
  - The pair advances only when tap_valid && mac_ready; with mac_ready=0, every output holds stable.
  - First pair is presented 1 cycle after entering SCAN.
  - Throughput with mac_ready=1: OR*OC*NPAIR cycles, which is 3380 at defaults.
- Pixel inputs in SCAN: pix_valid is ignored and buf_wr_en=0.
- DONE:
  - Entered when the last pair of the last window (OR-1, OC-1) is accepted.
  - done=1 for exactly one cycle; busy=0; tap_valid=0; then IDLE.
- start while busy or in DONE is ignored. The next start is honoured in IDLE, the cycle after done.

Optional Feature:
- Macro: ZERO_PAD_EN.
- Defined:
  - P=(K-1)/2; output grid is ROWS x COLS.
  - Tap coordinate is (out_row+kr-P, out_col+kc-P).
  - Out-of-range taps drive address 0 with tap_zero1/2=1; the MAC substitutes 0.
  - tap_valid stays 1 for padded taps.
  - Total pairs: ROWS*COLS*NPAIR.
- Undefined:
  - tap_zero1/2 tied 0; valid grid only; no padding logic synthesised.

Test Plan:
- Load with pix_valid toggling 1/0 for 784 pixels of value addr[7:0] -> 784 writes with buf_addr1 = 0..783 in order, pix_ready=0 after the last, SCAN entered.
- First window, mac_ready=1 -> pair0 addrs 0/1, pair1 2/28, pair2 29/30, pair3 56/57, pair4 58 with tap2_valid=0; tap_first on pair0, tap_last on pair4.
- Last window -> out_row=25, out_col=25, pair4 addr1=783; done pulses once after 3380 accepted pairs; busy falls.
- mac_ready held 0 for 5 cycles mid-window -> addrs and flags frozen; no pair lost or duplicated.
- rst pulsed at SCAN pair 100 -> all outputs 0 asynchronously, no done; a new start reloads cleanly. start while busy -> no effect.
- ZERO_PAD_EN, window (0,0) -> taps (-1,-1..1) and (0..1,-1) have tap_zero=1; tap4 address 0 is real data (tap_zero=0); 784 windows total.

Source files
------------

// File: rtl/conv_window_sched_if.sv
// Handshake and bus bundle for conv_window_sched.
//   master : scheduler side (drives busy/done, pixel ready, buffer and tap outputs)
//   slave  : environment side (sequencer start, pixel stream, MAC ready)
// Ports of the bundle:
//   start/busy/done             sequencer control
//   pix_valid/pix_ready/pix_data pixel input stream
//   buf_wr_en/buf_wr_data/buf_addr1/buf_addr2  image buffer
//   tap_valid/tap2_valid/tap_first/tap_last/tap_zero1/tap_zero2/out_row/out_col  MAC taps
//   mac_ready                   MAC accepts the current tap pair
interface conv_window_sched_if #(
  parameter int unsigned ROWS = 28,
  parameter int unsigned COLS = 28,
  parameter int unsigned AW   = 10
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          buf_wr_en;
  logic [7:0]    buf_wr_data;
  logic [AW-1:0] buf_addr1;
  logic [AW-1:0] buf_addr2;
  logic          tap_valid;
  logic          tap2_valid;
  logic          tap_first;
  logic          tap_last;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          tap_zero1;
  logic          tap_zero2;
  logic          mac_ready;

  modport master (
    input  start, pix_valid, pix_data, mac_ready,
    output busy, done, pix_ready, buf_wr_en, buf_wr_data, buf_addr1, buf_addr2,
           tap_valid, tap2_valid, tap_first, tap_last, out_row, out_col,
           tap_zero1, tap_zero2
  );

  modport slave (
    output start, pix_valid, pix_data, mac_ready,
    input  busy, done, pix_ready, buf_wr_en, buf_wr_data, buf_addr1, buf_addr2,
           tap_valid, tap2_valid, tap_first, tap_last, out_row, out_col,
           tap_zero1, tap_zero2
  );
endinterface

// File: rtl/conv_window_sched.sv
// Convolution window scheduler for the NPU image buffer.
// LOAD streams ROWS*COLS pixels into the buffer (write at port-1 address); SCAN walks every
// KxK window row-major and presents two tap addresses per cycle (tap 2p on port 1, tap 2p+1
// on port 2) with valid/first/last framing for the MAC array; DONE pulses done for one cycle.
// Ports: clk, rst (async, active-high), bus (conv_window_sched_if.master, see interface file).
// Optional feature macro ZERO_PAD_EN: same-size output grid with zero padding of
// out-of-range taps (address 0, tap_zero1/2 flags). Undefined: valid grid only, flags tied 0.
module conv_window_sched #(
  parameter int unsigned ROWS = 28,
  parameter int unsigned COLS = 28,
  parameter int unsigned K    = 3,
  parameter int unsigned AW   = 10
) (
  input  logic                clk,
  input  logic                rst,
  conv_window_sched_if.master bus
);
  localparam int NPIX  = int'(ROWS * COLS);
  localparam int NTAP  = int'(K * K);
  localparam int NPAIR = (NTAP + 1) / 2;
`ifdef ZERO_PAD_EN
  localparam int P     = (int'(K) - 1) / 2;
  localparam int OR    = int'(ROWS);
  localparam int OC    = int'(COLS);
`else
  localparam int OR    = int'(ROWS) - int'(K) + 1;
  localparam int OC    = int'(COLS) - int'(K) + 1;
`endif
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StScan, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d, row_n;
  logic [CW-1:0] col_q, col_d, col_n;
  logic [PW-1:0] pair_q, pair_d, pair_n;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [AW-1:0] addr2_q, addr2_d;
  logic          tv_q, tv_d;
  logic          tv2_q, tv2_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          load_pair;
  logic          clear_taps;
  int            ta, tb;
`ifdef ZERO_PAD_EN
  logic          z1_q, z1_d;
  logic          z2_q, z2_d;
`endif

  // Buffer address of tap t for the window whose output is (r, c).
  function automatic logic [AW-1:0] tap_addr(input int r, input int c, input int t);
    int y, x;
    y = r + t / int'(K);
    x = c + t % int'(K);
`ifdef ZERO_PAD_EN
    y = y - P;
    x = x - P;
    if (y < 0 || y >= int'(ROWS) || x < 0 || x >= int'(COLS)) return '0;
`endif
    return AW'(y * int'(COLS) + x);
  endfunction

`ifdef ZERO_PAD_EN
  function automatic logic tap_pad(input int r, input int c, input int t);
    int y, x;
    y = r + t / int'(K) - P;
    x = c + t % int'(K) - P;
    return (y < 0 || y >= int'(ROWS) || x < 0 || x >= int'(COLS));
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    pair_d     = pair_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    tv_d       = tv_q;
    tv2_d      = tv2_q;
    first_d    = first_q;
    last_d     = last_q;
`ifdef ZERO_PAD_EN
    z1_d       = z1_q;
    z2_d       = z2_q;
`endif
    row_n      = row_q;
    col_n      = col_q;
    pair_n     = pair_q;
    load_pair  = 1'b0;
    clear_taps = 1'b0;
    ta         = 0;
    tb         = 0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        // pix_ready is high for the whole state, so pix_valid alone is the handshake.
        if (bus.pix_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.pix_data;
          addr1_d   = cnt_q;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == AW'(NPIX - 1)) state_d = StScan;
        end
      end
      StScan: begin
        if (!tv_q) begin
          // Entry cycle: still showing the final write, fetch pair 0 of window (0,0).
          row_n     = '0;
          col_n     = '0;
          pair_n    = '0;
          load_pair = 1'b1;
        end else if (bus.mac_ready) begin
          if (pair_q == PW'(NPAIR - 1)) begin
            pair_n = '0;
            if (col_q == CW'(OC - 1)) begin
              col_n = '0;
              if (row_q == RW'(OR - 1)) begin
                state_d    = StDone;
                clear_taps = 1'b1;
              end else begin
                row_n = row_q + 1'b1;
              end
            end else begin
              col_n = col_q + 1'b1;
            end
          end else begin
            pair_n = pair_q + 1'b1;
          end
          load_pair = !clear_taps;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load_pair) begin
      ta      = 2 * int'(pair_n);
      tb      = ta + 1;
      row_d   = row_n;
      col_d   = col_n;
      pair_d  = pair_n;
      tv_d    = 1'b1;
      tv2_d   = (tb < NTAP);
      first_d = (pair_n == '0);
      last_d  = (pair_n == PW'(NPAIR - 1));
      addr1_d = tap_addr(int'(row_n), int'(col_n), ta);
      addr2_d = (tb < NTAP) ? tap_addr(int'(row_n), int'(col_n), tb) : '0;
`ifdef ZERO_PAD_EN
      z1_d    = tap_pad(int'(row_n), int'(col_n), ta);
      z2_d    = (tb < NTAP) && tap_pad(int'(row_n), int'(col_n), tb);
`endif
    end

    if (clear_taps) begin
      row_d   = '0;
      col_d   = '0;
      pair_d  = '0;
      tv_d    = 1'b0;
      tv2_d   = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      addr1_d = '0;
      addr2_d = '0;
`ifdef ZERO_PAD_EN
      z1_d    = 1'b0;
      z2_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pair_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      tv_q      <= 1'b0;
      tv2_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
`ifdef ZERO_PAD_EN
      z1_q      <= 1'b0;
      z2_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pair_q    <= pair_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
      tv_q      <= tv_d;
      tv2_q     <= tv2_d;
      first_q   <= first_d;
      last_q    <= last_d;
`ifdef ZERO_PAD_EN
      z1_q      <= z1_d;
      z2_q      <= z2_d;
`endif
    end
  end

  assign bus.busy        = (state_q == StLoad) || (state_q == StScan);
  assign bus.done        = (state_q == StDone);
  assign bus.pix_ready   = (state_q == StLoad);
  assign bus.buf_wr_en   = wr_en_q;
  assign bus.buf_wr_data = wr_data_q;
  assign bus.buf_addr1   = addr1_q;
  assign bus.buf_addr2   = addr2_q;
  assign bus.tap_valid   = tv_q;
  assign bus.tap2_valid  = tv2_q;
  assign bus.tap_first   = first_q;
  assign bus.tap_last    = last_q;
  assign bus.out_row     = row_q;
  assign bus.out_col     = col_q;
`ifdef ZERO_PAD_EN
  assign bus.tap_zero1   = z1_q;
  assign bus.tap_zero2   = z2_q;
`else
  assign bus.tap_zero1   = 1'b0;
  assign bus.tap_zero2   = 1'b0;
`endif
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched at default parameters (28x28, K=3, AW=10).
module tb_conv_window_sched;
  localparam int ROWS  = 28;
  localparam int COLS  = 28;
  localparam int K     = 3;
  localparam int AW    = 10;
  localparam int NPIX  = ROWS * COLS;
  localparam int NTAP  = K * K;
  localparam int NPAIR = 5;
`ifdef ZERO_PAD_EN
  localparam int P     = 1;
  localparam int OC    = COLS;
  localparam int TOTAL = 3920;
  localparam int LAST_RC = 27;
  localparam int LAST_A  = 0;
  localparam int LAST_Z  = 1;
  int ha [5] = '{0, 0, 0, 0, 29};
  int hb [5] = '{0, 0, 1, 28, 0};
  int hza[5] = '{1, 1, 0, 1, 0};
  int hzb[5] = '{1, 1, 0, 0, 0};
`else
  localparam int OC    = COLS - K + 1;
  localparam int TOTAL = 3380;
  localparam int LAST_RC = 25;
  localparam int LAST_A  = 783;
  localparam int LAST_Z  = 0;
  int ha [5] = '{0, 2, 29, 56, 58};
  int hb [5] = '{1, 28, 30, 57, 0};
  int hza[5] = '{0, 0, 0, 0, 0};
  int hzb[5] = '{0, 0, 0, 0, 0};
`endif
  int hv2[5] = '{1, 1, 1, 1, 0};

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  conv_window_sched_if #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) bus ();

  conv_window_sched #(.ROWS(ROWS), .COLS(COLS), .K(K), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_obs();
    logic [63:0] v;
    v = '0;
    v[35:0] = {bus.buf_addr1, bus.buf_addr2, bus.tap_valid, bus.tap2_valid, bus.tap_first,
               bus.tap_last, bus.tap_zero1, bus.tap_zero2, bus.out_row, bus.out_col};
    return v;
  endfunction

  function automatic logic [63:0] ctl_obs();
    logic [63:0] v;
    v = '0;
    v[11:0] = {bus.busy, bus.done, bus.pix_ready, bus.buf_wr_en, bus.buf_wr_data};
    return v;
  endfunction

  // Buffer address of tap t of window (r,c); -1 marks a padded tap.
  function automatic int model_addr(input int r, input int c, input int t);
    int y, x;
    y = r + t / K;
    x = c + t % K;
`ifdef ZERO_PAD_EN
    y = y - P;
    x = x - P;
    if (y < 0 || y >= ROWS || x < 0 || x >= COLS) return -1;
`endif
    return y * COLS + x;
  endfunction

  function automatic logic [63:0] exp_pair(input int k);
    int w, p, r, c, a1, a2;
    logic v2, z1, z2;
    logic [63:0] v;
    w  = k / NPAIR;
    p  = k % NPAIR;
    r  = w / OC;
    c  = w % OC;
    v2 = (2 * p + 1) < NTAP;
    a1 = model_addr(r, c, 2 * p);
    a2 = v2 ? model_addr(r, c, 2 * p + 1) : 0;
    z1 = (a1 < 0);
    z2 = (a2 < 0);
    if (z1) a1 = 0;
    if (z2) a2 = 0;
    v = '0;
    v[35:0] = {10'(a1), 10'(a2), 1'b1, v2, p == 0, p == NPAIR - 1, z1, z2, 5'(r), 5'(c)};
    return v;
  endfunction

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_busy", {bus.busy, bus.pix_ready}, 2'b11);
  endtask

  task automatic do_load(input bit toggle);
    int sent = 0;
    int seen = 0;
    int cyc  = 0;
    bit v    = 1'b1;
    while (seen < NPIX && cyc < 4000) begin
      bus.pix_valid = v;
      bus.pix_data  = 8'(sent);
      if (bus.pix_ready && v) sent++;
      if (toggle) v = !v;
      @(posedge clk); #1;
      cyc++;
      if (bus.buf_wr_en) begin
        check("wr_addr", bus.buf_addr1, seen);
        check("wr_data", bus.buf_wr_data, seen & 255);
        seen++;
      end
    end
    bus.pix_valid = 1'b1;
    check("load_count", seen, NPIX);
    check("ready_drop", bus.pix_ready, 0);
    check("scan_entry", {bus.busy, bus.tap_valid}, 2'b10);
  endtask

  task automatic do_scan(input int abort_at, input bit do_stall);
    int k     = 0;
    int cyc   = 0;
    int stall = 0;
    bit fin   = 1'b0;
    logic [63:0] frozen = '0;
    bus.mac_ready = 1'b1;
    while (!fin && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (bus.done) begin
        check("done_count", k, TOTAL);
        check("done_flags", {bus.busy, bus.tap_valid}, 0);
        check("scan_cycles", cyc, TOTAL + (do_stall ? 5 : 0) + 1);
        fin = 1'b1;
      end else if (bus.tap_valid) begin
        check("pair", pack_obs(), exp_pair(k));
        check("scan_ctl", {bus.pix_ready, bus.buf_wr_en}, 0);
        if (k < 5) begin
          check("hand_a", bus.buf_addr1, ha[k]);
          check("hand_b", bus.buf_addr2, hb[k]);
          check("hand_flags",
                {bus.tap2_valid, bus.tap_first, bus.tap_last, bus.tap_zero1, bus.tap_zero2},
                {hv2[k][0], k == 0, k == 4, hza[k][0], hzb[k][0]});
        end
        if (k == TOTAL - 1) begin
          check("last_rc", {bus.out_row, bus.out_col}, {5'(LAST_RC), 5'(LAST_RC)});
          check("last_a", {bus.buf_addr1, bus.tap_zero1}, {10'(LAST_A), 1'(LAST_Z)});
        end
        if (k == abort_at) begin
          rst = 1'b1;
          #1;
          check("abort_obs", pack_obs(), 0);
          check("abort_ctl", ctl_obs(), 0);
          repeat (2) @(posedge clk);
          #1;
          check("abort_nodone", {bus.done, bus.busy}, 0);
          rst = 1'b0;
          return;
        end
        if (k == 50) bus.start = 1'b1;
        if (do_stall && k == 10 && stall > 0) check("stall_hold", pack_obs(), frozen);
        if (do_stall && k == 10 && stall < 5) begin
          if (stall == 0) frozen = pack_obs();
          bus.mac_ready = 1'b0;
          stall++;
        end else begin
          bus.mac_ready = 1'b1;
          k++;
        end
      end else begin
        check("tap_gap", bus.tap_valid, 1);
      end
    end
    if (!fin) check("scan_timeout", 0, 1);
    @(posedge clk); #1;
    check("post_done", {bus.done, bus.busy}, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'd0;
    bus.mac_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_obs", pack_obs(), 0);
    check("rst_ctl", ctl_obs(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle", ctl_obs(), 0);

    do_start();
    do_load(1'b1);
    do_scan(-1, 1'b1);

    do_start();
    do_load(1'b0);
    do_scan(100, 1'b0);

    do_start();
    do_load(1'b0);
    do_scan(-1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
